hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 8-bit RISC core. Complements operand forwarding by handling the hazards forwarding cannot resolve.
- Load-use: inserts a one-cycle stall plus bubble.
- Taken branch: flushes the wrong-path instructions, with a configurable number of extra refetch bubbles.
- Data-memory wait: freezes the whole pipeline while the MEM-stage memory handshake is pending.
- Sits beside the IF/ID and ID/EX pipeline registers and drives their write-enable, flush and hold controls.

Parameters:
- REG_ADDR_W, 2, register address width (4-entry register file).
- FLUSH_EXTRA, 1, bubble cycles after a taken branch beyond the resolve cycle (0..7).
- STALL_CNT_W, 8, width of the saturating stall counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- if_id_ra  in  REG_ADDR_W  source A of the instruction in decode.
- if_id_rb  in  REG_ADDR_W  source B of the instruction in decode.
- if_id_uses_rb  in  1  decode instruction actually reads rb.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rd  in  REG_ADDR_W  destination of the instruction in EX.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  MEM stage has an active data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_bubble  out  1  load NOP into ID/EX.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- stall_count  out  STALL_CNT_W  count of cycles with pc_write=0.

Behaviour:
- FSM states (hazard_pkg::state_t): RUN, FLUSH, MEM_WAIT. Reset state is RUN. Flush counter flush_left (3 bits) resets to 0.
- While rst=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_hold=0. stall_count is cleared and does not count.
- Outputs are combinational from state and inputs (zero-latency stall). State and counters are registered.
- memwait = mem_req & ~mem_ready.
- loaduse = id_ex_mem_read & (id_ex_rd==if_id_ra | (if_id_uses_rb & id_ex_rd==if_id_rb)).
- RUN default outputs: pc_write=1, if_id_write=1, all other outputs 0.
- RUN rules, in priority order:
  1. memwait: pc_write=0, if_id_write=0, pipe_hold=1. Next state MEM_WAIT. Branch and load-use are ignored this cycle.
  2. branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1. If FLUSH_EXTRA>0, next state FLUSH with flush_left=FLUSH_EXTRA; otherwise stay in RUN. Load-use is ignored because the decode instruction is wrong-path.
  3. loaduse: pc_write=0, if_id_write=0, id_ex_bubble=1. Stay in RUN; the next cycle re-evaluates naturally (EX then holds a bubble).
- MEM_WAIT:
  - While memwait: same outputs as RUN rule 1, and stay in MEM_WAIT.
  - When mem_ready=1 (or mem_req drops): behave exactly as RUN for that cycle, including branch and load-use rules and the next-state choice.
- FLUSH:
  - If memwait: freeze outputs as in RUN rule 1, hold flush_left, stay in FLUSH.
  - Otherwise: pc_write=1, if_id_write=1, if_id_flush=1, flush_left decrements. Return to RUN when flush_left reaches 1→0.
  - branch_taken and loaduse are ignored in FLUSH; EX holds bubbles.
- stall_count: increments every non-reset cycle with pc_write=0. Saturates at all-ones with no wrap.
- Reset asserted mid-FLUSH or mid-MEM_WAIT: the next state is RUN and flush_left=0 unconditionally.

Optional Feature:
- HAZARD_PERF_EN defined: adds three 16-bit saturating output ports, each cleared by rst:
  - load_stall_cnt: counts load-use cycles.
  - branch_flush_cnt: counts taken branches.
  - mem_wait_cnt: counts memwait cycles.
- HAZARD_PERF_EN not defined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- hazard_pkg holds:
  - state_t enum: RUN, FLUSH, MEM_WAIT.
  - REG_ADDR_W default constant.
  - NOP-control constants.
- One sub-module, sat_counter (parameterised width, inc and clr inputs). It is used for stall_count and for the optional perf counters.

Test Plan:
1. Load-use: id_ex_mem_read=1, id_ex_rd=2, if_id_ra=2 for one cycle → pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_count 0→1.
2. No false stall: id_ex_mem_read=1, id_ex_rd=3, if_id_rb=3, if_id_uses_rb=0 → no stall, stall_count unchanged.
3. Branch with FLUSH_EXTRA=1: branch_taken pulse at cycle 0 → cycle 0 if_id_flush=1 and id_ex_bubble=1; cycle 1 if_id_flush=1 only; cycle 2 all defaults.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → pipe_hold=1 for 3 cycles and 0 on the 4th; stall_count +3.
5. Simultaneous: memwait + branch_taken + loaduse together → hold only. On the ready cycle the branch flush fires and the load-use is ignored.
6. Reset and saturation:
   - rst asserted in FLUSH → RUN next cycle with defaults.
   - 300 consecutive stall cycles → stall_count=255.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the default register-address width and the
// canned control patterns driven onto the IF/ID and ID/EX registers.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // 4-entry register file by default.
    localparam int DEF_REG_ADDR_W = 2;

    // Bundle of the pipeline-register controls the block drives.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_hold;
    } ctrl_t;

    // Normal flow: fetch and decode advance, nothing squashed.
    localparam ctrl_t CTRL_RUN   = 5'b11000;
    // Whole-pipeline freeze while the data memory is busy.
    localparam ctrl_t CTRL_HOLD  = 5'b00001;
    // Reset: front end stopped, NOPs loaded into IF/ID and ID/EX.
    localparam ctrl_t CTRL_RESET = 5'b00110;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects an inc one clock after it is sampled.
// Backpressure: none; sticks at all-ones instead of wrapping.
//
// Ports: clk, clr (sync clear, wins over inc), inc (count this cycle),
//        count (current value).
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, data-memory freeze.
// Latency: zero; controls are combinational from state and inputs, state is registered.
// Backpressure: freezes the whole pipeline while a MEM-stage access is pending.
//
// Ports: clk, rst (sync, active-high); decode sources if_id_ra/if_id_rb/if_id_uses_rb;
//        EX load info id_ex_mem_read/id_ex_rd; branch_taken; mem_req/mem_ready handshake.
//        Outputs pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall_count.
// Optional: define HAZARD_PERF_EN to add load_stall_cnt, branch_flush_cnt, mem_wait_cnt.
import hazard_pkg::*;

module hazard_controller #(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int FLUSH_EXTRA = 1,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  if_id_ra,
    input  logic [REG_ADDR_W-1:0]  if_id_rb,
    input  logic                   if_id_uses_rb,
    input  logic                   id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  id_ex_rd,
    input  logic                   branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   pipe_hold,
    output logic [STALL_CNT_W-1:0] stall_count
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]            load_stall_cnt,
    output logic [15:0]            branch_flush_cnt,
    output logic [15:0]            mem_wait_cnt
`endif
);

    state_t     state_q, state_d;
    logic [2:0] flush_left_q, flush_left_d;
    ctrl_t      ctrl;
    logic       memwait;
    logic       loaduse;

    assign memwait = mem_req & ~mem_ready;
    assign loaduse = id_ex_mem_read &
                     ((id_ex_rd == if_id_ra) | (if_id_uses_rb & (id_ex_rd == if_id_rb)));

    always_comb begin
        ctrl         = CTRL_RUN;
        state_d      = state_q;
        flush_left_d = flush_left_q;
        if (rst) begin
            ctrl         = CTRL_RESET;
            state_d      = RUN;
            flush_left_d = 3'd0;
        end else begin
            unique case (state_q)
                // MEM_WAIT falls through to the RUN rules on the ready cycle.
                RUN, MEM_WAIT: begin
                    if (memwait) begin
                        ctrl    = CTRL_HOLD;
                        state_d = MEM_WAIT;
                    end else if (branch_taken) begin
                        // Decode holds a wrong-path instruction, so load-use is moot.
                        ctrl.if_id_flush  = 1'b1;
                        ctrl.id_ex_bubble = 1'b1;
                        if (FLUSH_EXTRA > 0) begin
                            state_d      = FLUSH;
                            flush_left_d = 3'(FLUSH_EXTRA);
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                        if (loaduse) begin
                            ctrl.pc_write     = 1'b0;
                            ctrl.if_id_write  = 1'b0;
                            ctrl.id_ex_bubble = 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (memwait) begin
                        ctrl = CTRL_HOLD;
                    end else begin
                        ctrl.if_id_flush = 1'b1;
                        flush_left_d     = flush_left_q - 3'd1;
                        if (flush_left_q <= 3'd1) begin
                            state_d      = RUN;
                            flush_left_d = 3'd0;
                        end
                    end
                end
                default: begin
                    state_d      = RUN;
                    flush_left_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            flush_left_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign pipe_hold    = ctrl.pipe_hold;

    // pc_write is also low during reset, so reset cycles are masked out.
    sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (~ctrl.pc_write & ~rst),
        .count (stall_count)
    );

`ifdef HAZARD_PERF_EN
    // Each rule leaves a unique control signature, so the counters decode the
    // applied action rather than the raw inputs (ignored hazards do not count).
    logic lu_fire, br_fire, mw_fire;
    assign lu_fire = ~rst & ctrl.id_ex_bubble & ~ctrl.if_id_flush;
    assign br_fire = ~rst & ctrl.id_ex_bubble &  ctrl.if_id_flush;
    assign mw_fire = ~rst & ctrl.pipe_hold;

    sat_counter #(.WIDTH(16)) u_load_stall_cnt (
        .clk(clk), .clr(rst), .inc(lu_fire), .count(load_stall_cnt)
    );
    sat_counter #(.WIDTH(16)) u_branch_flush_cnt (
        .clk(clk), .clr(rst), .inc(br_fire), .count(branch_flush_cnt)
    );
    sat_counter #(.WIDTH(16)) u_mem_wait_cnt (
        .clk(clk), .clr(rst), .inc(mw_fire), .count(mem_wait_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller with default parameters
// (REG_ADDR_W=2, FLUSH_EXTRA=1, STALL_CNT_W=8).
// Inputs change 1ns after posedge; outputs are compared at negedge.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] if_id_ra, if_id_rb, id_ex_rd;
    logic       if_id_uses_rb, id_ex_mem_read, branch_taken, mem_req, mem_ready;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;
    logic [7:0] stall_count;
`ifdef HAZARD_PERF_EN
    logic [15:0] load_stall_cnt, branch_flush_cnt, mem_wait_cnt;
`endif

    always #5 clk = ~clk;

    hazard_controller dut (
        .clk            (clk),
        .rst            (rst),
        .if_id_ra       (if_id_ra),
        .if_id_rb       (if_id_rb),
        .if_id_uses_rb  (if_id_uses_rb),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .branch_taken   (branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .pipe_hold      (pipe_hold),
        .stall_count    (stall_count)
`ifdef HAZARD_PERF_EN
        ,
        .load_stall_cnt   (load_stall_cnt),
        .branch_flush_cnt (branch_flush_cnt),
        .mem_wait_cnt     (mem_wait_cnt)
`endif
    );

    // Control bits ordered {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_LU    = 5'b00010;
    localparam logic [4:0] C_BR    = 5'b11110;
    localparam logic [4:0] C_FL    = 5'b11100;
    localparam logic [4:0] C_HOLD  = 5'b00001;
    localparam logic [4:0] C_RESET = 5'b00110;

    typedef struct {
        logic [1:0] ra;
        logic [1:0] rb;
        logic       uses_rb;
        logic       mem_read;
        logic [1:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [4:0] exp_ctrl;
        logic [7:0] exp_sc;   // stall_count seen in this cycle (before its own increment)
    } vec_t;

    vec_t vecs[21];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic [1:0] ra, input logic [1:0] rb,
                                input logic uses_rb, input logic mem_read,
                                input logic [1:0] rd, input logic br,
                                input logic req, input logic rdy,
                                input logic [4:0] exp_ctrl, input logic [7:0] exp_sc);
        vec_t v;
        v.ra = ra; v.rb = rb; v.uses_rb = uses_rb; v.mem_read = mem_read; v.rd = rd;
        v.br = br; v.req = req; v.rdy = rdy; v.exp_ctrl = exp_ctrl; v.exp_sc = exp_sc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic drive(input vec_t v);
        if_id_ra = v.ra; if_id_rb = v.rb; if_id_uses_rb = v.uses_rb;
        id_ex_mem_read = v.mem_read; id_ex_rd = v.rd; branch_taken = v.br;
        mem_req = v.req; mem_ready = v.rdy;
    endtask

    function automatic logic [4:0] ctrl_now();
        return {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold};
    endfunction

    initial begin
        vec_t idle;
        idle = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, C_RUN, 8'd0);

        //            ra    rb    urb   mrd   rd    br    req   rdy   ctrl    sc
        vecs[0]  = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, C_RUN,  8'd0); // idle
        vecs[1]  = mk(2'd2, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, C_LU,   8'd0); // load-use on ra
        vecs[2]  = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, C_RUN,  8'd1);
        vecs[3]  = mk(2'd0, 2'd3, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, C_RUN,  8'd1); // rb not used
        vecs[4]  = mk(2'd0, 2'd3, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, C_LU,   8'd1); // rb used
        vecs[5]  = mk(2'd2, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, C_RUN,  8'd2); // not a load
        vecs[6]  = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, C_BR,   8'd2); // branch
        vecs[7]  = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, C_FL,   8'd2); // extra bubble
        vecs[8]  = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, C_RUN,  8'd2);
        vecs[9]  = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, C_HOLD, 8'd2); // memwait x3
        vecs[10] = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, C_HOLD, 8'd3);
        vecs[11] = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, C_HOLD, 8'd4);
        vecs[12] = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, C_RUN,  8'd5); // ready
        vecs[13] = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, C_RUN,  8'd5);
        vecs[14] = mk(2'd1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, C_HOLD, 8'd5); // all three
        vecs[15] = mk(2'd1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, C_BR,   8'd6); // ready: branch wins
        vecs[16] = mk(2'd1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, C_HOLD, 8'd6); // memwait in FLUSH
        vecs[17] = mk(2'd1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, C_FL,   8'd7); // FLUSH ignores hazards
        vecs[18] = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, C_RUN,  8'd7);
        vecs[19] = mk(2'd3, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, C_LU,   8'd7); // load-use on rb
        vecs[20] = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, C_RUN,  8'd8);

        // Reset state
        rst = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 32'(ctrl_now()), 32'(C_RESET));
        check("reset_stall_count", 32'(stall_count), 32'd0);

        // Table sequence
        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d_ctrl", i), 32'(ctrl_now()), 32'(vecs[i].exp_ctrl));
            check($sformatf("vec%0d_stall_count", i), 32'(stall_count), 32'(vecs[i].exp_sc));
        end

        // Reset asserted while in FLUSH returns to RUN with counters cleared
        @(posedge clk); #1;
        drive(mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, C_BR, 8'd0));
        @(negedge clk);
        check("rstflush_branch_ctrl", 32'(ctrl_now()), 32'(C_BR));
        @(posedge clk); #1;
        rst = 1'b1;
        drive(idle);
        @(negedge clk);
        check("rstflush_during_rst_ctrl", 32'(ctrl_now()), 32'(C_RESET));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstflush_after_ctrl", 32'(ctrl_now()), 32'(C_RUN));
        check("rstflush_after_stall_count", 32'(stall_count), 32'd0);

        // Saturation: 300 consecutive frozen cycles
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            drive(mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, C_HOLD, 8'd0));
        end
        @(negedge clk);
        check("sat_hold_ctrl", 32'(ctrl_now()), 32'(C_HOLD));
        @(posedge clk); #1;
        drive(idle);
        @(negedge clk);
        check("sat_stall_count", 32'(stall_count), 32'd255);
        check("sat_release_ctrl", 32'(ctrl_now()), 32'(C_RUN));
        @(posedge clk); #1;
        @(negedge clk);
        check("sat_no_wrap", 32'(stall_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
